// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder_pkg : shared format/error codes, opcodes, field struct |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_MISAL = 2'b10,
    ERR_FMT   = 2'b11
  } err_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

endpackage
`default_nettype wire

// File: rtl/instr_encoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder_if : upstream field handshake and downstream word bus  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;

  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_pack : combinational RV32I field packing and error checking    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] instr,
  output logic [1:0]  err
);

  logic [31:0] raw;
  logic        range_bad;
  logic        misal;
  logic        fmt_bad;

  always_comb begin
    raw       = '0;
    range_bad = 1'b0;
    misal     = 1'b0;
    fmt_bad   = 1'b0;
    case (f.fmt)
      FMT_R: raw = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I: begin
        raw       = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        range_bad = ~((&f.imm[31:11]) | ~(|f.imm[31:11]));
      end
      FMT_S: begin
        raw       = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
        range_bad = ~((&f.imm[31:11]) | ~(|f.imm[31:11]));
      end
      FMT_B: begin
        raw       = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                     f.imm[4:1], f.imm[11], f.opcode};
        range_bad = ~((&f.imm[31:12]) | ~(|f.imm[31:12]));
        misal     = f.imm[0];
      end
      FMT_U: begin
        raw       = {f.imm[31:12], f.rd, f.opcode};
        range_bad = |f.imm[11:0];
      end
      FMT_J: begin
        raw       = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
        range_bad = ~((&f.imm[31:20]) | ~(|f.imm[31:20]));
        misal     = f.imm[0];
      end
      default: fmt_bad = 1'b1;
    endcase
  end

  // Priority: bad format, then misalignment, then range.
  always_comb begin
    if (fmt_bad)        err = ERR_FMT;
    else if (misal)     err = ERR_MISAL;
    else if (range_bad) err = ERR_RANGE;
    else                err = ERR_NONE;
    instr = (err == ERR_NONE) ? raw : NOP_INSTR;
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_encoder : two-stage elastic RV32I instruction encoder          |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_encoder_if.slave    bus,
  output logic [CNT_W-1:0]  enc_count
);

  fields_t     s1_f;
  logic        s1_valid;
  logic        s2_valid;
  logic [31:0] s2_instr;
  logic [1:0]  s2_err;
  logic [31:0] pack_instr;
  logic [1:0]  pack_err;
  logic        s2_adv;
  logic        s1_adv;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_f <= '{fmt: bus.in_fmt, opcode: bus.in_opcode, funct3: bus.in_funct3,
                  funct7: bus.in_funct7, rd: bus.in_rd, rs1: bus.in_rs1,
                  rs2: bus.in_rs2, imm: bus.in_imm};
      end
    end
  end

  instr_pack u_pack (
    .f     (s1_f),
    .instr (pack_instr),
    .err   (pack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= ERR_NONE;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_instr <= pack_instr;
        s2_err   <= pack_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (s2_valid && bus.out_ready && (s2_err == ERR_NONE) && (enc_count != '1)) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_instr = s2_instr;
  assign bus.out_err   = s2_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_encoder : directed self-checking bench for instr_encoder    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] enc_count;
  int          checks;
  int          failures;
  int          exp_cnt;

  instr_encoder_if bus ();

  instr_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_fmt    = fmt;
    bus.in_opcode = op;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask

  // Entry already presented to an empty pipe with out_ready high.
  task automatic expect_out(input string tag, input logic [31:0] ei, input logic [1:0] ee);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(bus.out_instr), 64'(ei));
    chk({tag, "_err"}, 64'(bus.out_err), 64'(ee));
    if (ee == 2'b00) exp_cnt++;
    @(posedge clk); #1;
    chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_count"}, 64'(enc_count), 64'(exp_cnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    rst_n    = 1'b0;
    present(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_count", 64'(enc_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    present(3'd1, OP_OPIMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
    expect_out("addi", 32'hFFF10093, 2'b00);
    present(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    expect_out("beq", 32'hFE000EE3, 2'b00);
    present(3'd4, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    expect_out("lui", 32'h123452B7, 2'b00);
    present(3'd0, OP_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF);
    expect_out("add_r", 32'h002081B3, 2'b00);
    present(3'd2, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'h00000008);
    expect_out("sw", 32'h00512423, 2'b00);
    present(3'd5, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800);
    expect_out("jal_2048", 32'h001000EF, 2'b00);

    present(3'd5, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000003);
    expect_out("jal_misal", 32'h00000013, 2'b10);
    present(3'd1, OP_OPIMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h00000800);
    expect_out("addi_range", 32'h00000013, 2'b01);
    present(3'd7, OP_OPIMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'h00000003);
    expect_out("fmt_bad", 32'h00000013, 2'b11);
    present(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h00001000);
    expect_out("beq_range", 32'h00000013, 2'b01);
    present(3'd4, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00000001);
    expect_out("lui_range", 32'h00000013, 2'b01);

    // Backpressure from a fresh reset so the count restarts.
    rst_n = 1'b0;
    #2;
    rst_n   = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    present(3'd1, OP_OPIMM, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF);
    @(posedge clk); #1;
    present(3'd0, OP_OP, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    chk("bp_ready_b", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    present(3'd2, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 32'h00000008);
    chk("bp_ready_c", 64'(bus.in_ready), 64'd0);
    chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_stall_instr", 64'(bus.out_instr), 64'hFFF10093);
      chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_out_b", 64'(bus.out_instr), 64'h002081B3);
    @(posedge clk); #1;
    chk("bp_out_c", 64'(bus.out_instr), 64'h00512423);
    chk("bp_out_c_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    chk("bp_drain", 64'(bus.out_valid), 64'd0);
    chk("bp_count", 64'(enc_count), 64'd3);

    // Asynchronous reset while an output is waiting.
    bus.out_ready = 1'b0;
    present(3'd4, OP_LUI, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_count", 64'(enc_count), 64'd0);
    chk("ar_instr", 64'(bus.out_instr), 64'd0);
    chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    exp_cnt = 0;
    present(3'd3, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC);
    #2;
    rst_n = 1'b1;
    expect_out("ar_beq", 32'hFE000EE3, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
